// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR decimator input packer.
// Latency: none (declarations only).
// Backpressure: n/a.
package fir_pkg;

    localparam int CHANNELS = 2;
    localparam int DW       = 16;
    localparam int PSAMPLES = 8;
    localparam int PACK_W   = CHANNELS * PSAMPLES * DW;
    localparam int LCW      = $clog2(PSAMPLES);

    typedef logic signed [DW-1:0]    sample_t;
    typedef sample_t [CHANNELS-1:0]  pair_t;
    typedef logic [PACK_W-1:0]       packed_word_t;

    // IDLE: no partial word held; FILL: 0 < lane_cnt < PSAMPLES.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_e;

    // Bit offset of channel c, lane l inside a packed word.
    function automatic int lane_lsb(input int c, input int l);
        return (c * PSAMPLES + l) * DW;
    endfunction

endpackage

// File: rtl/fir_hold_reg.sv
// Single-entry valid/ready holding register; loads and drains in the same cycle.
// Latency: 1 cycle from input handshake to out_vld_o.
// Backpressure: in_rdy_o = empty or draining this cycle; out_vld_o is registered.
// Ports: clk_i/rst_i (async active-high), in_* producer side, out_* consumer side.
module fir_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    logic         full_q, full_d;
    logic [W-1:0] dat_q, dat_d;

    assign in_rdy_o  = !full_q || out_rdy_i;
    assign out_vld_o = full_q;
    assign out_dat_o = dat_q;

    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (in_vld_i && in_rdy_o) begin
            // A load wins over a drain: the slot stays full with new data.
            full_d = 1'b1;
            dat_d  = in_dat_i;
        end else if (out_rdy_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

endmodule

// File: rtl/fir_lane_packer.sv
// Packs PSAMPLES consecutive {ch1,ch0} sample pairs into one wide word for the FIR.
// Latency: m_tvalid rises 1 cycle after the word-completing pair is accepted.
// Backpressure: only a word-completing beat stalls, and only while the held word is not draining.
// Ports: clk, rst (async active-high); s_t* pair input stream; m_t* packed word output;
// words_out counts output handshakes. Optional FIR_PACK_FLUSH_EN adds s_tlast/m_tlast:
// a tlast beat closes the word early with unfilled lanes zeroed.
module fir_lane_packer
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [CHANNELS*DW-1:0]   s_tdata,
`ifdef FIR_PACK_FLUSH_EN
    input  logic                     s_tlast,
`endif
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [PACK_W-1:0]        m_tdata,
`ifdef FIR_PACK_FLUSH_EN
    output logic                     m_tlast,
`endif
    output logic [31:0]              words_out
);

    pack_state_e                state_q, state_d;
    logic [LCW-1:0]             lane_cnt_q, lane_cnt_d;
    pair_t [PSAMPLES-2:0]       asm_q;
    logic                       rdy_en_q;
    logic [31:0]                words_q;

    logic                       beat_last;
    logic                       closes_word;
    logic                       hold_in_rdy;
    logic                       accept;
    logic                       complete;
    packed_word_t               word_d;

`ifdef FIR_PACK_FLUSH_EN
    assign beat_last = s_tlast;
`else
    assign beat_last = 1'b0;
`endif

    // The beat in lane PSAMPLES-1 (or a tlast beat) closes the word and must
    // find the holding register free or draining.
    assign closes_word = (lane_cnt_q == LCW'(PSAMPLES - 1)) || beat_last;
    // rdy_en_q keeps s_tready low through reset and for the release cycle.
    assign s_tready    = rdy_en_q && !(closes_word && !hold_in_rdy);
    assign accept      = s_tvalid && s_tready;
    assign complete    = accept && closes_word;

    // Lanes below lane_cnt come from the assembly register, the current lane
    // from the incoming beat; lanes above stay zero (only reachable on flush).
    always_comb begin
        word_d = '0;
        for (int l = 0; l < PSAMPLES - 1; l++) begin
            if (state_q == FILL && l < int'(lane_cnt_q)) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    word_d[lane_lsb(c, l) +: DW] = asm_q[l][c];
                end
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            word_d[(c * PSAMPLES + int'(lane_cnt_q)) * DW +: DW] = s_tdata[c * DW +: DW];
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        if (accept) begin
            if (closes_word) begin
                state_d    = IDLE;
                lane_cnt_d = '0;
            end else begin
                state_d    = FILL;
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            asm_q      <= '0;
            rdy_en_q   <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            rdy_en_q   <= 1'b1;
            if (accept && !closes_word) begin
                asm_q[lane_cnt_q] <= pair_t'(s_tdata);
            end
            if (m_tvalid && m_tready) begin
                words_q <= words_q + 32'd1;
            end
        end
    end

    assign words_out = words_q;

`ifdef FIR_PACK_FLUSH_EN
    localparam int HOLD_W = PACK_W + 1;
    logic [HOLD_W-1:0] hold_in, hold_out;
    assign hold_in = {beat_last, word_d};
    assign m_tdata = hold_out[PACK_W-1:0];
    assign m_tlast = hold_out[PACK_W];
`else
    localparam int HOLD_W = PACK_W;
    logic [HOLD_W-1:0] hold_in, hold_out;
    assign hold_in = word_d;
    assign m_tdata = hold_out;
`endif

    fir_hold_reg #(
        .W (HOLD_W)
    ) u_hold (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_vld_i  (complete),
        .in_rdy_o  (hold_in_rdy),
        .in_dat_i  (hold_in),
        .out_vld_o (m_tvalid),
        .out_rdy_i (m_tready),
        .out_dat_o (hold_out)
    );

endmodule

// File: tb/tb_fir_lane_packer.sv
// Scoreboard bench for fir_lane_packer: accepted pairs are repacked by a
// reference model into expected words, compared when the DUT hands words off.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_fir_lane_packer;
    import fir_pkg::*;

    typedef logic [PACK_W:0] ow_t;   // {last, word}

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   s_tvalid = 1'b0;
    logic                   s_tready;
    logic [CHANNELS*DW-1:0] s_tdata = '0;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic [PACK_W-1:0]      m_tdata;
    logic [31:0]            words_out;
`ifdef FIR_PACK_FLUSH_EN
    logic                   s_tlast = 1'b0;
    logic                   m_tlast;
`endif

    int total = 0;
    int bad   = 0;

    ow_t               exp_q[$];
    logic [PACK_W-1:0] acc   = '0;
    int                acc_n = 0;

    always #5 clk = ~clk;

    fir_lane_packer dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
`ifdef FIR_PACK_FLUSH_EN
        .s_tlast   (s_tlast),
        .m_tlast   (m_tlast),
`endif
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .words_out (words_out)
    );

    function automatic ow_t dut_out();
`ifdef FIR_PACK_FLUSH_EN
        return {m_tlast, m_tdata};
`else
        return {1'b0, m_tdata};
`endif
    endfunction

    function automatic logic cur_last();
`ifdef FIR_PACK_FLUSH_EN
        return s_tlast;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference repacking: called at the falling edge with the beat on the bus.
    task automatic sample_in(input logic last);
        if (s_tvalid && s_tready) begin
            for (int c = 0; c < CHANNELS; c++)
                acc[(c * PSAMPLES + acc_n) * DW +: DW] = s_tdata[c * DW +: DW];
            acc_n++;
            if (acc_n == PSAMPLES || last) begin
                exp_q.push_back({last, acc});
                acc   = '0;
                acc_n = 0;
            end
        end
    endtask

    task automatic model_reset();
        acc   = '0;
        acc_n = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %b want 0", m_tvalid); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL rst_mdata: got %h want 0", m_tdata); end
        total++; if (words_out !== 32'd0) begin bad++; $display("FAIL rst_words: got %0d want 0", words_out); end
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_sready: got %b want 0", s_tready); end
`ifdef FIR_PACK_FLUSH_EN
        total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_mlast: got %b want 0", m_tlast); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_release_sready: got %b want 1", s_tready); end
        model_reset();
        tick();
    endtask

    task automatic test_basic();
        int i = 0, got = 0, beat_cyc = -1, vld_cyc = -1;
        ow_t ew;
        ow_t exp_c = '0;
        for (int l = 0; l < PSAMPLES; l++) begin
            exp_c[l * DW +: DW]              = 16'(l);
            exp_c[(PSAMPLES + l) * DW +: DW] = 16'(16'h0100 + l);
        end
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_tvalid = (i < 8);
            s_tdata  = {16'(16'h0100 + i), 16'(i)};
            @(negedge clk);
            if (m_tvalid && vld_cyc < 0) vld_cyc = cyc;
            sample_in(cur_last());
            if (s_tvalid && s_tready) begin
                if (i == 7) beat_cyc = cyc;
                i++;
            end
            if (m_tvalid && m_tready) begin
                got++;
                total++;
                if (dut_out() !== exp_c) begin bad++; $display("FAIL t1_lanes: got %h want %h", dut_out(), exp_c); end
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t1_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t1_word: got %h want %h", dut_out(), ew); end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        total++; if (vld_cyc !== beat_cyc + 1) begin bad++; $display("FAIL t1_latency: valid cycle %0d, last beat cycle %0d", vld_cyc, beat_cyc); end
        total++; if (got !== 1) begin bad++; $display("FAIL t1_count: got %0d words want 1", got); end
        @(negedge clk);
        total++; if (words_out !== 32'd1) begin bad++; $display("FAIL t1_words_out: got %0d want 1", words_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int i = 0, got = 0, last_cyc = 0;
        ow_t ew;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            s_tvalid = (i < 64);
            s_tdata  = $urandom;
            @(negedge clk);
            if (s_tvalid) begin
                total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL t2_sready: cycle %0d got %b want 1", cyc, s_tready); end
            end
            sample_in(cur_last());
            if (s_tvalid && s_tready) i++;
            if (m_tvalid && m_tready) begin
                total++;
                if (cyc - last_cyc !== 8) begin bad++; $display("FAIL t2_spacing: word %0d at cycle %0d, previous %0d, want gap 8", got, cyc, last_cyc); end
                last_cyc = cyc;
                got++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t2_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t2_word: got %h want %h", dut_out(), ew); end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        total++; if (got !== 8) begin bad++; $display("FAIL t2_count: got %0d words want 8", got); end
        @(negedge clk);
        total++; if (words_out !== 32'd9) begin bad++; $display("FAIL t2_words_out: got %0d want 9", words_out); end
        tick();
    endtask

    task automatic test_backpressure();
        int i = 0, got = 0;
        ow_t ew;
        for (int cyc = 0; cyc < 36; cyc++) begin
            m_tready = (cyc >= 25);
            s_tvalid = (i < 16);
            s_tdata  = {16'(16'h3000 + i), 16'(16'h2000 + i)};
            @(negedge clk);
            if (i == 15 && !m_tready) begin
                total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL t3_stall: cycle %0d s_tready %b want 0", cyc, s_tready); end
            end
            if (m_tvalid && !m_tready && exp_q.size() != 0) begin
                total++; if (dut_out() !== exp_q[0]) begin bad++; $display("FAIL t3_hold: got %h want %h", dut_out(), exp_q[0]); end
            end
            if (cyc == 24) begin
                total++; if (i !== 15) begin bad++; $display("FAIL t3_accepted: got %0d pairs want 15", i); end
            end
            sample_in(cur_last());
            if (s_tvalid && s_tready) i++;
            if (m_tvalid && m_tready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t3_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t3_word: got %h want %h", dut_out(), ew); end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        total++; if (got !== 2) begin bad++; $display("FAIL t3_count: got %0d words want 2", got); end
        @(negedge clk);
        total++; if (words_out !== 32'd11) begin bad++; $display("FAIL t3_words_out: got %0d want 11", words_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        int i = 0, got = 0;
        ow_t ew;
        ow_t exp_c = '0;
        for (int k = 0; k < CHANNELS * PSAMPLES; k++) exp_c[k * DW +: DW] = 16'h7FFF;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            s_tvalid = 1'b1;
            s_tdata  = {16'(16'h0A00 + cyc), 16'(16'h0B00 + cyc)};
            tick();
        end
        s_tvalid = 1'b0;
        #3 rst = 1'b1;
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL t4_rst_mvalid: got %b want 0", m_tvalid); end
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL t4_rst_sready: got %b want 0", s_tready); end
        total++; if (words_out !== 32'd0) begin bad++; $display("FAIL t4_rst_words: got %0d want 0", words_out); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_tvalid = (i < 8);
            s_tdata  = {16'h7FFF, 16'h7FFF};
            @(negedge clk);
            sample_in(cur_last());
            if (s_tvalid && s_tready) i++;
            if (m_tvalid && m_tready) begin
                got++;
                total++;
                if (dut_out() !== exp_c) begin bad++; $display("FAIL t4_all7fff: got %h want %h", dut_out(), exp_c); end
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t4_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t4_word: got %h want %h", dut_out(), ew); end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        total++; if (got !== 1) begin bad++; $display("FAIL t4_count: got %0d words want 1", got); end
        @(negedge clk);
        total++; if (words_out !== 32'd1) begin bad++; $display("FAIL t4_words_out: got %0d want 1", words_out); end
        tick();
    endtask

    task automatic test_flush();
        int i = 0, got = 0;
        ow_t ew;
        ow_t exp_c = '0;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < CHANNELS; c++) exp_c[(c * PSAMPLES + l) * DW +: DW] = 16'h1234;
        exp_c[PACK_W] = 1'b1;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            s_tvalid = (i < 3);
            s_tdata  = {16'h1234, 16'h1234};
`ifdef FIR_PACK_FLUSH_EN
            s_tlast  = (i == 2);
`endif
            @(negedge clk);
            sample_in(cur_last());
            if (s_tvalid && s_tready) i++;
            if (m_tvalid && m_tready) begin
                got++;
`ifdef FIR_PACK_FLUSH_EN
                total++;
                if (dut_out() !== exp_c) begin bad++; $display("FAIL t5_flush_word: got %h want %h", dut_out(), exp_c); end
`endif
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t5_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t5_word: got %h want %h", dut_out(), ew); end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
`ifdef FIR_PACK_FLUSH_EN
        s_tlast  = 1'b0;
        total++; if (got !== 1) begin bad++; $display("FAIL t5_count: got %0d words want 1", got); end
`else
        total++; if (got !== 0) begin bad++; $display("FAIL t5_count: got %0d words want 0", got); end
        total++; if (i !== 3) begin bad++; $display("FAIL t5_accepted: got %0d pairs want 3", i); end
`endif
        do_reset();
    endtask

    task automatic test_random();
        int i = 0, got = 0, cyc = 0;
        bit hs = 1'b0;
        ow_t ew;
        s_tvalid = 1'b0;
        while (cyc < 40000 && !(i >= 4096 && exp_q.size() == 0)) begin
            if (!s_tvalid || hs) begin
                s_tvalid = (i < 4096) && ($urandom_range(0, 1) == 1);
                s_tdata  = $urandom;
            end
            m_tready = (i >= 4096) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = s_tvalid && s_tready;
            if (m_tvalid && !m_tready && exp_q.size() != 0) begin
                total++; if (dut_out() !== exp_q[0]) begin bad++; $display("FAIL t6_hold: got %h want %h", dut_out(), exp_q[0]); end
            end
            sample_in(cur_last());
            if (hs) i++;
            if (m_tvalid && m_tready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t6_word: got %h, no word expected", dut_out()); end
                else begin
                    ew = exp_q.pop_front();
                    if (dut_out() !== ew) begin bad++; $display("FAIL t6_word: word %0d got %h want %h", got, dut_out(), ew); end
                end
            end
            tick();
            cyc++;
        end
        s_tvalid = 1'b0;
        total++; if (i !== 4096) begin bad++; $display("FAIL t6_budget: accepted %0d pairs want 4096", i); end
        total++; if (got !== 512) begin bad++; $display("FAIL t6_count: got %0d words want 512", got); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL t6_leftover: %0d words never emitted, want 0", exp_q.size()); end
        @(negedge clk);
        total++; if (words_out !== 32'd512) begin bad++; $display("FAIL t6_words_out: got %0d want 512", words_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
